pipe_mdu: RTL and testbench

Iterative multiply/divide unit that executes the `mul`, `multu`, `div` and `divu` operations issued by the ID-stage control unit and owns the HI/LO register pair. It sits beside the ALU in the EX stage. `busy` feeds the decoder's stall logic, and `hi`/`lo` feed the forwarding and write-back muxes.

---
 rtl/pipe_mdu_pkg.sv | 38 +++
 rtl/pipe_mdu_step.sv | 35 +++
 rtl/pipe_mdu.sv | 138 +++++++++++++
 tb/tb_pipe_mdu.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states, latched per-operation control and divide-by-zero constants.
package pipe_mdu_pkg;

    localparam logic [1:0] MDU_MUL   = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    // Quotient on divide by zero is all ones (sliced to XLEN by the user).
    // The remainder on divide by zero is the raw dividend; the restoring
    // loop produces that on its own, so no constant is needed for HI.
    localparam int                      MDU_MAX_XLEN = 64;
    localparam logic [MDU_MAX_XLEN-1:0] DIV0_LO      = '1;

    // Control captured at issue and consumed in FIX.
    typedef struct packed {
        logic is_div;  // divide (1) or multiply (0)
        logic neg_q;   // negate product / quotient
        logic neg_r;   // negate remainder (dividend was negative)
        logic div0;    // divisor was zero
    } mdu_ctl_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/pipe_mdu_step.sv
// One radix-2 iteration of the MDU datapath: right-shifting shift-add for
// multiply, left-shifting restoring subtract for divide. Purely combinational.
module pipe_mdu_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_out
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] diff;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {remainder, dividend bits shifting into quotient}.
    always_comb begin
        sum     = {1'b0, acc_in[2*XLEN-1:XLEN]} + {1'b0, opnd};
        rem_sh  = acc_in[2*XLEN-1:XLEN-1];
        diff    = rem_sh[XLEN-1:0] - opnd;
        acc_out = acc_in;
        if (is_div) begin
            if (rem_sh >= {1'b0, opnd})
                acc_out = {diff, acc_in[XLEN-2:0], 1'b1};
            else
                acc_out = {rem_sh[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
        end else if (acc_in[0]) begin
            acc_out = {sum, acc_in[XLEN-1:1]};
        end else begin
            acc_out = {1'b0, acc_in[2*XLEN-1:1]};
        end
    end

endmodule

// File: rtl/pipe_mdu.sv
// Iterative multiply/divide unit owning HI/LO. Operands are converted to
// magnitudes at issue, iterated XLEN times, and sign-fixed in FIX.
// Optional feature macro: PIPE_MDU_FAST_MUL_EN (single-cycle multiplier for
// mul/multu, FSM goes IDLE->FIX; divides stay iterative).
module pipe_mdu
    import pipe_mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            cancel,
    input  logic            w_hi,
    input  logic            w_lo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    mdu_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc, acc_step, acc_fix;
    logic [XLEN-1:0]   opnd, a_mag, b_mag, hi_fix, lo_fix;
    mdu_ctl_t          ctl, ctl_new;
    logic              issue, commit;

    assign issue  = (state == IDLE) && start && !cancel;
    assign commit = (state == FIX) && !cancel;

    // Magnitudes: |0x80000000| is 0x80000000 as unsigned, which also makes
    // 0x80000000 / -1 come out as 0x80000000 rem 0 without a special case.
    assign a_mag = (op_is_signed(op) && a[XLEN-1]) ? -a : a;
    assign b_mag = (op_is_signed(op) && b[XLEN-1]) ? -b : b;

    assign ctl_new.is_div = op_is_div(op);
    assign ctl_new.neg_q  = op_is_signed(op) && (a[XLEN-1] ^ b[XLEN-1]);
    assign ctl_new.neg_r  = op_is_signed(op) && a[XLEN-1];
    assign ctl_new.div0   = op_is_div(op) && (b == '0);

`ifdef PIPE_MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

    pipe_mdu_step #(.XLEN(XLEN)) u_step (
        .is_div  (ctl.is_div),
        .acc_in  (acc),
        .opnd    (opnd),
        .acc_out (acc_step)
    );

    // Next-state: cancel overrides everything and returns to IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) begin
`ifdef PIPE_MDU_FAST_MUL_EN
                state_nxt = op_is_div(op) ? CALC : FIX;
`else
                state_nxt = CALC;
`endif
            end
            CALC:    if (cnt == '1) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (cancel) state_nxt = IDLE;
    end

    // Sign fix-up of the magnitude result; divide by zero forces LO.
    always_comb begin
        acc_fix = ctl.neg_q ? -acc : acc;
        hi_fix  = acc_fix[2*XLEN-1:XLEN];
        lo_fix  = acc_fix[XLEN-1:0];
        if (ctl.is_div) begin
            lo_fix = ctl.div0  ? DIV0_LO[XLEN-1:0]
                   : ctl.neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
            hi_fix = ctl.neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        end
    end

    // Operand capture at issue, then one iteration per CALC cycle.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            acc  <= '0;
            opnd <= '0;
            ctl  <= '0;
            cnt  <= '0;
        end else if (issue) begin
            ctl  <= ctl_new;
            opnd <= b_mag;
            cnt  <= '0;
`ifdef PIPE_MDU_FAST_MUL_EN
            acc  <= op_is_div(op) ? {{XLEN{1'b0}}, a_mag} : fast_prod;
`else
            acc  <= {{XLEN{1'b0}}, a_mag};
`endif
        end else if (state == CALC) begin
            acc <= acc_step;
            cnt <= cnt + CNT_W'(1);
        end
    end

    // FSM state plus registered busy/done so neither output glitches.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= commit;
        end
    end

    // HI/LO: result write in FIX, mthi/mtlo only when idle and not issuing.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            hi <= hi_fix;
            lo <= lo_fix;
        end else if (state == IDLE && !start && !cancel) begin
            if (w_hi) hi <= wdata;
            if (w_lo) lo <= wdata;
        end
    end

endmodule

// File: tb/tb_pipe_mdu.sv
// Directed self-checking bench for pipe_mdu: one task per scenario.
module tb_pipe_mdu;

    logic        clk, clrn, start, cancel, w_hi, w_lo;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    pipe_mdu #(.XLEN(32), .CNT_W(5)) dut (
        .clk(clk), .clrn(clrn), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .w_hi(w_hi), .w_lo(w_lo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue at the next edge (T0) and wait for done, bounded to 100 edges.
    task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                          output int edges, output int busy_cnt, output logic first_done);
        op = o; a = va; b = vb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        first_done = done;
        busy_cnt = busy ? 1 : 0;
        edges = 0;
        while (!done && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic write_hilo(input logic whi, input logic wlo, input logic [31:0] d);
        w_hi = whi; w_lo = wlo; wdata = d;
        @(posedge clk); #1;
        w_hi = 1'b0; w_lo = 1'b0;
    endtask

    task automatic test_reset();
        clrn = 1'b1;
        #2 clrn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %h exp 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
        @(negedge clk) clrn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_multu();
        int e, bc; logic fd;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e, bc, fd);
        checks++; if (e !== 33) begin errors++; $display("FAIL multu_latency got %0d exp 33", e); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL multu_busy_cycles got %0d exp 33", bc); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h exp fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h exp 00000001", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done got %h exp 0", busy); end
    endtask

    task automatic test_mul_signed();
        int e, bc; logic fd;
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, e, bc, fd);
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mul_hi got %h exp ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mul_lo got %h exp fffffff1", lo); end
    endtask

    task automatic test_back_to_back();
        int e, bc; logic fd;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, e, bc, fd);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", hi); end
        // issued while done is still high
        run_op(2'b11, 32'd7, 32'd2, e, bc, fd);
        checks++; if (fd !== 1'b0) begin errors++; $display("FAIL b2b_done_twice got %h exp 0", fd); end
        checks++; if (e !== 33) begin errors++; $display("FAIL b2b_latency got %0d exp 33", e); end
        checks++; if (lo !== 32'd3) begin errors++; $display("FAIL divu_lo got %h exp 3", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL divu_hi got %h exp 1", hi); end
    endtask

    task automatic test_div_corner();
        int e, bc; logic fd;
        run_op(2'b11, 32'h0000_1234, 32'h0, e, bc, fd);
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo got %h exp ffffffff", lo); end
        checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL divu0_hi got %h exp 1234", hi); end
        run_op(2'b10, 32'hFFFF_FFFB, 32'h0, e, bc, fd);
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo got %h exp ffffffff", lo); end
        checks++; if (hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL div0_hi got %h exp fffffffb", hi); end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, e, bc, fd);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL ovf_lo got %h exp 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ovf_hi got %h exp 0", hi); end
    endtask

    task automatic test_mthi_mtlo();
        int e, bc; logic fd;
        write_hilo(1'b1, 1'b1, 32'h0000_AAAA);
        checks++; if (hi !== 32'h0000_AAAA) begin errors++; $display("FAIL mthi_both got %h exp aaaa", hi); end
        checks++; if (lo !== 32'h0000_AAAA) begin errors++; $display("FAIL mtlo_both got %h exp aaaa", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy got %h exp 0", busy); end
        write_hilo(1'b0, 1'b1, 32'h0000_5555);
        checks++; if (lo !== 32'h0000_5555) begin errors++; $display("FAIL mtlo got %h exp 5555", lo); end
        // start and mtlo together: start wins, write dropped
        w_lo = 1'b1; wdata = 32'h0000_1111;
        op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; w_lo = 1'b0;
        checks++; if (lo !== 32'h0000_5555) begin errors++; $display("FAIL start_wins_lo got %h exp 5555", lo); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_wins_busy got %h exp 1", busy); end
        e = 0;
        while (!done && e < 100) begin @(posedge clk); #1; e++; end
        checks++; if (lo !== 32'd6) begin errors++; $display("FAIL start_wins_result got %h exp 6", lo); end
    endtask

    task automatic test_cancel();
        int npulse;
        write_hilo(1'b1, 1'b0, 32'h0000_AAAA);
        write_hilo(1'b0, 1'b1, 32'h0000_5555);
        op = 2'b00; a = 32'd3; b = 32'd4; start = 1'b1;
        @(posedge clk); #1;                 // T0
        start = 1'b0;
        repeat (4) @(posedge clk);          // T4
        #1;
        start = 1'b1; w_lo = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1;                 // T5: both ignored
        start = 1'b0; w_lo = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_ignore_busy got %h exp 1", busy); end
        checks++; if (lo !== 32'h0000_5555) begin errors++; $display("FAIL busy_ignore_lo got %h exp 5555", lo); end
        repeat (4) @(posedge clk);          // T9
        #1 cancel = 1'b1;
        @(posedge clk); #1;                 // T10
        cancel = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got %h exp 0", busy); end
        npulse = 0;
        repeat (40) begin
            if (done) npulse++;
            @(posedge clk); #1;
        end
        checks++; if (npulse !== 0) begin errors++; $display("FAIL cancel_done got %0d exp 0", npulse); end
        checks++; if (hi !== 32'h0000_AAAA) begin errors++; $display("FAIL cancel_hi got %h exp aaaa", hi); end
        checks++; if (lo !== 32'h0000_5555) begin errors++; $display("FAIL cancel_lo got %h exp 5555", lo); end
        // cancel with start in IDLE: nothing issued
        op = 2'b11; a = 32'd9; b = 32'd3; start = 1'b1; cancel = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_start_busy got %h exp 0", busy); end
    endtask

    task automatic test_fast_mul();
        int e, bc; logic fd;
        run_op(2'b01, 32'd6, 32'd7, e, bc, fd);
`ifdef PIPE_MDU_FAST_MUL_EN
        checks++; if (e !== 1) begin errors++; $display("FAIL fast_latency got %0d exp 1", e); end
        checks++; if (bc !== 1) begin errors++; $display("FAIL fast_busy_cycles got %0d exp 1", bc); end
`else
        checks++; if (e !== 33) begin errors++; $display("FAIL mul_latency got %0d exp 33", e); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL mul_busy_cycles got %0d exp 33", bc); end
`endif
        checks++; if (lo !== 32'd42) begin errors++; $display("FAIL fast_lo got %h exp 2a", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL fast_hi got %h exp 0", hi); end
        // divides stay on the iterative path in either build
        run_op(2'b11, 32'd100, 32'd7, e, bc, fd);
        checks++; if (e !== 33) begin errors++; $display("FAIL div_latency got %0d exp 33", e); end
        checks++; if (lo !== 32'd14 || hi !== 32'd2) begin
            errors++; $display("FAIL divu_100_7 got %h/%h exp e/2", lo, hi);
        end
    endtask

    task automatic test_async_reset();
        write_hilo(1'b1, 1'b1, 32'h0000_0077);
        op = 2'b11; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;                 // T0
        start = 1'b0;
        repeat (20) @(posedge clk);         // T20
        #2 clrn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %h exp 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL areset_hi got %h exp 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL areset_lo got %h exp 0", lo); end
        @(negedge clk) clrn = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL areset_no_resume got done=%h busy=%h exp 0/0", done, busy);
        end
    endtask

    initial begin
        start = 1'b0; cancel = 1'b0; w_hi = 1'b0; w_lo = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        test_reset();
        test_multu();
        test_mul_signed();
        test_back_to_back();
        test_div_corner();
        test_mthi_mtlo();
        test_cancel();
        test_fast_mul();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
